cla_sum_serializer: RTL and testbench

Transmit end of the adder datapath: captures a registered CLA result (WIDTH-bit sum plus carry-out) through a valid/ready handshake and shifts it out LSB-first on a single-bit serial line with per-bit valid and end-of-frame markers. It sits downstream of the adder's output flip-flops and drives the serial link toward the off-block result consumer. Back-to-back frames are supported with no idle gap.

---
 rtl/cla_sum_serializer.sv | 122 ++++++++++++
 tb/tb_cla_sum_serializer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/cla_sum_serializer.sv
// cla_sum_serializer: captures a CLA result {in_cout, in_sum} through a
// valid/ready handshake and shifts it out LSB-first on ser_out. Each frame
// bit is flagged by ser_valid, and ser_last marks the final bit. A new
// result can be accepted on the ser_last cycle, so frames can follow each
// other with no idle gap.
//
// Optional feature macro: SER_PARITY_EN. When it is defined, an even-parity
// bit (XOR of in_sum and in_cout) is appended after in_cout, so
// FLEN = WIDTH+2. When it is undefined, FLEN = WIDTH+1 and no parity logic
// is built.
//
// Handshake: a result is accepted on a rising clk edge where
// in_valid && in_ready. in_ready depends only on state and counter, never on
// in_valid. Upstream holds in_valid and its data until the result is
// accepted. There is no downstream back-pressure: once a frame starts, it
// runs for FLEN consecutive cycles.
//
// busy mirrors the FSM state (1 = SHIFT) and is the state debug output.
module cla_sum_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_cout,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

`ifdef SER_PARITY_EN
  localparam int FLEN = WIDTH + 2;
`else
  localparam int FLEN = WIDTH + 1;
`endif
  localparam int CW = $clog2(FLEN + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(FLEN - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [FLEN-1:0] r_shift;
  logic [FLEN-1:0] w_shift_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [FLEN-1:0] w_load;
  logic            w_last;
  logic            w_accept;

  // Frame image, LSB first: sum bits, then carry, then the optional parity bit.
`ifdef SER_PARITY_EN
  assign w_load = {^{in_cout, in_sum}, in_cout, in_sum};
`else
  assign w_load = {in_cout, in_sum};
`endif

  assign w_last    = (r_state == SHIFT) && (r_cnt == LAST_CNT);
  assign in_ready  = (r_state == IDLE) || w_last;
  assign w_accept  = in_valid && in_ready;

  assign ser_valid = (r_state == SHIFT);
  assign busy      = (r_state == SHIFT);
  assign ser_last  = w_last;
  assign ser_out   = (r_state == SHIFT) && r_shift[0];

  // State, shift register and bit counter; reset has priority over accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: load on accept, shift while framing, and on the last bit
  // either reload back-to-back or return to idle.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_accept) begin
          w_state_nxt = SHIFT;
          w_shift_nxt = w_load;
        end
      end
      SHIFT: begin
        if (w_last) begin
          w_cnt_nxt = '0;
          if (w_accept) begin
            w_shift_nxt = w_load;
          end else begin
            w_state_nxt = IDLE;
            w_shift_nxt = '0;
          end
        end else begin
          w_shift_nxt = {1'b0, r_shift[FLEN-1:1]};
          w_cnt_nxt   = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_shift_nxt = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_cla_sum_serializer.sv
// Directed bench for cla_sum_serializer (WIDTH=8). Expected frames are
// hand-computed 10-bit images {parity, cout, sum}; the parity bit is used
// only when SER_PARITY_EN is defined.
module tb_cla_sum_serializer;
  localparam int WIDTH = 8;
`ifdef SER_PARITY_EN
  localparam int FLEN = WIDTH + 2;
`else
  localparam int FLEN = WIDTH + 1;
`endif

  // Clock and reset signals
  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_sum;
  logic             in_cout;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_last;
  logic             busy;

  always #5 clk = ~clk;

  cla_sum_serializer #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sum   (in_sum),
    .in_cout  (in_cout),
    .ser_out  (ser_out),
    .ser_valid(ser_valid),
    .ser_last (ser_last),
    .busy     (busy)
  );

  // Scoreboard: expected frame images, in the order they are accepted
  logic [9:0] exp_q[$];
  logic [9:0] f;
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ser_valid"}, 32'(ser_valid), 32'd0);
    chk({tag, "_ser_out"},   32'(ser_out),   32'd0);
    chk({tag, "_ser_last"},  32'(ser_last),  32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
  endtask

  task automatic chk_bit(input string tag, input logic [9:0] fr, input int i);
    string t;
    t = $sformatf("%s_b%0d", tag, i);
    chk({t, "_ser_valid"}, 32'(ser_valid), 32'd1);
    chk({t, "_busy"},      32'(busy),      32'd1);
    chk({t, "_ser_out"},   32'(ser_out),   32'(fr[i]));
    chk({t, "_ser_last"},  32'(ser_last),  32'(i == FLEN - 1));
    chk({t, "_in_ready"},  32'(in_ready),  32'(i == FLEN - 1));
  endtask

  initial begin
    // Reset: hold rst for two cycles
    rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_cout = 1'b0;
    step(); step();
    rst = 1'b0;
    chk_idle("reset");

    // Single frame A5 / cout 1 -> 1,0,1,0,0,1,0,1,1 (parity 1)
    in_valid = 1'b1; in_sum = 8'hA5; in_cout = 1'b1; exp_q.push_back(10'h3A5);
    chk("a5_ready_before", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0; in_sum = 8'h00; in_cout = 1'b0;
    f = exp_q.pop_front();
    for (int i = 0; i < FLEN; i++) begin chk_bit("a5", f, i); step(); end
    chk_idle("a5_done");

    // Back-to-back: 01/0 then FF/1 with in_valid held high
    in_valid = 1'b1; in_sum = 8'h01; in_cout = 1'b0; exp_q.push_back(10'h201);
    step();
    in_sum = 8'hFF; in_cout = 1'b1; exp_q.push_back(10'h3FF);
    f = exp_q.pop_front();
    for (int i = 0; i < FLEN; i++) begin chk_bit("b2b0", f, i); step(); end
    in_valid = 1'b0;
    f = exp_q.pop_front();
    for (int i = 0; i < FLEN; i++) begin chk_bit("b2b1", f, i); step(); end
    chk_idle("b2b_done");

    // Stall: input changes mid-frame are ignored; 96/1 is taken on ser_last
    in_valid = 1'b1; in_sum = 8'h5A; in_cout = 1'b0; exp_q.push_back(10'h05A);
    step();
    f = exp_q.pop_front();
    for (int i = 0; i < FLEN; i++) begin
      if (i == FLEN - 1) begin
        in_sum = 8'h96; in_cout = 1'b1; exp_q.push_back(10'h396);
      end else begin
        in_sum = 8'(8'hC3 + i * 8'h11); in_cout = i[0];
      end
      chk_bit("stall", f, i);
      step();
    end
    in_valid = 1'b0;
    f = exp_q.pop_front();
    for (int i = 0; i < FLEN; i++) begin chk_bit("stall_next", f, i); step(); end
    chk_idle("stall_done");

    // Reset wins over an accept while idle
    in_valid = 1'b1; in_sum = 8'hEE; in_cout = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk_idle("rst_prio");

    // Mid-frame reset during the 5th bit of 3C, then 81/0 sent from bit 0
    in_valid = 1'b1; in_sum = 8'h3C; in_cout = 1'b0; exp_q.push_back(10'h03C);
    step();
    in_valid = 1'b0;
    f = exp_q.pop_front();
    for (int i = 0; i < 4; i++) begin chk_bit("midrst", f, i); step(); end
    chk_bit("midrst", f, 4);
    rst = 1'b1; in_valid = 1'b1; in_sum = 8'h81; in_cout = 1'b0;
    step();
    rst = 1'b0;
    chk_idle("midrst_abort");
    exp_q.push_back(10'h081);
    step();
    in_valid = 1'b0;
    f = exp_q.pop_front();
    for (int i = 0; i < FLEN; i++) begin chk_bit("after_rst", f, i); step(); end
    chk_idle("after_rst_done");

    // 07/0: parity build frame is 1,1,1,0,0,0,0,0,0,1
    in_valid = 1'b1; in_sum = 8'h07; in_cout = 1'b0; exp_q.push_back(10'h207);
    step();
    in_valid = 1'b0;
    f = exp_q.pop_front();
    for (int i = 0; i < FLEN; i++) begin chk_bit("x07", f, i); step(); end
    chk_idle("x07_done");

    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
